// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and line constants for the USB TX line stage (polarity via ENC_LOW_SPEED_EN)
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_line_state_t;

`ifdef ENC_LOW_SPEED_EN
  // Low-speed idle (J) is D- high.
  localparam logic J_DP = 1'b0;
  localparam logic J_DM = 1'b1;
  localparam logic K_DP = 1'b1;
  localparam logic K_DM = 1'b0;
`else
  // Full-speed idle (J) is D+ high.
  localparam logic J_DP = 1'b1;
  localparam logic J_DM = 1'b0;
  localparam logic K_DP = 1'b0;
  localparam logic K_DM = 1'b1;
`endif

  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_STUFF_LEN    = 6;
  localparam int DEF_EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_bit_timer.sv
// rtl/usb_bit_timer.sv - bit-period counter with clear and last-cycle flag
module usb_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic last_cycle
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  // Count clocks within a bit period; held at zero while clear is high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign last_cycle = (count == LAST);

endmodule

// File: rtl/usb_tx_line_encoder.sv
// rtl/usb_tx_line_encoder.sv - NRZI encoder with bit stuffing and EOP generation (ENC_LOW_SPEED_EN selects low-speed polarity)
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STUFF_LEN    = DEF_STUFF_LEN,
  parameter int EOP_SE0_BITS = DEF_EOP_SE0_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic bit_valid,
  input  logic bit_in,
  output logic bit_ready,
  input  logic eop_req,
  output logic busy,
  output logic underrun,
  output logic d_plus,
  output logic d_minus
);

  tx_line_state_t state;
  logic [3:0]     ones_cnt;
  logic [1:0]     se0_cnt;
  logic           last_cycle;
  logic           timer_clear;
  logic           stuff_pending;
  logic           accept;

  // The period counter sits at zero in IDLE so the first bit starts a full period.
  assign timer_clear = (state == IDLE);

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (timer_clear),
    .last_cycle(last_cycle)
  );

  assign stuff_pending = (ones_cnt == 4'(STUFF_LEN));
  assign accept        = bit_valid && bit_ready;

  // Accept a new bit in IDLE, or at the end of a data/stuff period unless a stuff bit or EOP takes it.
  always_comb begin
    bit_ready = 1'b0;
    case (state)
      IDLE:        bit_ready = 1'b1;
      DATA, STUFF: bit_ready = last_cycle && !stuff_pending && !eop_req;
      default:     bit_ready = 1'b0;
    endcase
  end

  // Line sequencer: NRZI data, forced stuff periods, then SE0 and J to close the packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      d_plus   <= J_DP;
      d_minus  <= J_DM;
      busy     <= 1'b0;
      underrun <= 1'b0;
      ones_cnt <= 4'd0;
      se0_cnt  <= 2'd0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= DATA;
            busy     <= 1'b1;
            ones_cnt <= {3'd0, bit_in};
            if (!bit_in) begin
              d_plus  <= ~d_plus;
              d_minus <= ~d_minus;
            end
          end
        end
        DATA, STUFF: begin
          if (last_cycle) begin
            if (stuff_pending) begin
              state    <= STUFF;
              ones_cnt <= 4'd0;
              d_plus   <= ~d_plus;
              d_minus  <= ~d_minus;
            end else if (accept) begin
              state <= DATA;
              if (bit_in) begin
                ones_cnt <= ones_cnt + 4'd1;
              end else begin
                ones_cnt <= 4'd0;
                d_plus   <= ~d_plus;
                d_minus  <= ~d_minus;
              end
            end else begin
              // Either a requested EOP or the source ran dry; both close the packet.
              state    <= EOP_SE0;
              se0_cnt  <= 2'd0;
              d_plus   <= 1'b0;
              d_minus  <= 1'b0;
              underrun <= !eop_req;
            end
          end
        end
        EOP_SE0: begin
          if (last_cycle) begin
            if (se0_cnt == 2'(EOP_SE0_BITS - 1)) begin
              state   <= EOP_J;
              d_plus  <= J_DP;
              d_minus <= J_DM;
            end else begin
              se0_cnt <= se0_cnt + 2'd1;
            end
          end
        end
        EOP_J: begin
          if (last_cycle) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ones_cnt <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// tb/tb_usb_tx_line_encoder.sv - self-checking bench for usb_tx_line_encoder
module tb_usb_tx_line_encoder;

  localparam int C    = 8;
  localparam int SL   = 6;
  localparam int SE0B = 2;

`ifdef ENC_LOW_SPEED_EN
  localparam logic [1:0] J_SYM = 2'b01;
`else
  localparam logic [1:0] J_SYM = 2'b10;
`endif

  logic clk       = 1'b0;
  logic n_rst     = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in    = 1'b0;
  logic eop_req   = 1'b0;
  logic bit_ready;
  logic busy;
  logic underrun;
  logic d_plus;
  logic d_minus;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_sym[$];
  bit         exp_stuff[$];
  int         ndata;
  logic       pk[$];

  always #5 clk = ~clk;

  usb_tx_line_encoder #(
    .CLKS_PER_BIT(C),
    .STUFF_LEN   (SL),
    .EOP_SE0_BITS(SE0B)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .bit_ready(bit_ready),
    .eop_req  (eop_req),
    .busy     (busy),
    .underrun (underrun),
    .d_plus   (d_plus),
    .d_minus  (d_minus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected per-period line symbols: NRZI of the bits with stuff zeros, then SE0 periods and J.
  function automatic void build(input logic bits[$]);
    logic [1:0] cur;
    int ones;
    cur  = J_SYM;
    ones = 0;
    exp_sym.delete();
    exp_stuff.delete();
    foreach (bits[j]) begin
      if (bits[j]) ones++;
      else begin
        cur  = ~cur;
        ones = 0;
      end
      exp_sym.push_back(cur);
      exp_stuff.push_back(1'b0);
      if (ones == SL) begin
        cur  = ~cur;
        ones = 0;
        exp_sym.push_back(cur);
        exp_stuff.push_back(1'b1);
      end
    end
    ndata = exp_sym.size();
    for (int j = 0; j < SE0B; j++) begin
      exp_sym.push_back(2'b00);
      exp_stuff.push_back(1'b0);
    end
    exp_sym.push_back(J_SYM);
    exp_stuff.push_back(1'b0);
  endfunction

  task automatic set_bits(input logic [15:0] pat, input int n);
    pk.delete();
    for (int j = n - 1; j >= 0; j--) pk.push_back(pat[j]);
  endtask

  task automatic run_packet(input logic bits[$], input bit use_eop, input int abort_k);
    int   total;
    int   n;
    int   i;
    int   s;
    logic exp_rdy;
    build(bits);
    total = exp_sym.size() * C;
    n     = bits.size();
    i     = 0;
    @(negedge clk);
    check("pre_line", {d_plus, d_minus}, J_SYM);
    check("pre_busy", busy, 0);
    bit_valid = 1'b1;
    bit_in    = bits[0];
    eop_req   = 1'b0;
    #1 check("pre_ready", bit_ready, 1);
    if (bit_valid && bit_ready) i = 1;
    for (int k = 0; k < total + 2; k++) begin
      @(negedge clk);
      check("line", {d_plus, d_minus}, (k < total) ? exp_sym[k / C] : J_SYM);
      check("busy", busy, (k < total) ? 1 : 0);
      check("underrun", underrun, (!use_eop && k == ndata * C) ? 1 : 0);
      if (k == abort_k) begin
        bit_valid = 1'b0;
        eop_req   = 1'b0;
        #1 n_rst = 1'b0;
        #1;
        check("rst_line", {d_plus, d_minus}, J_SYM);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", bit_ready, 1);
        @(negedge clk);
        n_rst = 1'b1;
        return;
      end
      if (k >= total) begin
        bit_valid = 1'b0;
        eop_req   = 1'b0;
      end else if (i < n) begin
        bit_valid = 1'b1;
        bit_in    = bits[i];
        eop_req   = 1'b0;
      end else if (use_eop) begin
        eop_req   = 1'b1;
        bit_valid = 1'($urandom_range(0, 1));
        bit_in    = 1'($urandom_range(0, 1));
      end else begin
        bit_valid = 1'b0;
        eop_req   = 1'b0;
      end
      s = k / C + 1;
      if (k >= total) exp_rdy = 1'b1;
      else exp_rdy = (k < ndata * C) && (k % C == C - 1)
                     && !(s < ndata && exp_stuff[s]) && !eop_req;
      #1 check("ready", bit_ready, exp_rdy);
      if (bit_valid && bit_ready) i++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_line", {d_plus, d_minus}, J_SYM);
    check("reset_busy", busy, 0);
    check("reset_underrun", underrun, 0);
    n_rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_line", {d_plus, d_minus}, J_SYM);
      check("idle_ready", bit_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_underrun", underrun, 0);
    end

    set_bits(16'b0010, 4);
    run_packet(pk, 1'b1, -1);

    set_bits(16'hFF, 8);
    run_packet(pk, 1'b1, -1);

    set_bits(16'h3F, 6);
    run_packet(pk, 1'b1, -1);

    set_bits(16'b1011101, 7);
    run_packet(pk, 1'b0, -1);

    set_bits(16'h1F, 5);
    run_packet(pk, 1'b1, 5 * C + 4);

    set_bits(16'b11101111111, 11);
    run_packet(pk, 1'b1, -1);

    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 16);
      pk.delete();
      for (int j = 0; j < len; j++) pk.push_back(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      run_packet(pk, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
